glyph_raster_reader: RTL and testbench
======================================

Name: glyph_raster_reader

Overview:
- Reader side of the 16x16 character-glyph ROMs. Each ROM is a combinational row lookup: 4-bit row address in, 16-bit row word out, bit 0 = leftmost pixel.
- On a start pulse, the block walks glyph rows 0..15 and latches each ROM row word. It then serializes the row one pixel per accepted transfer, using a valid/ready handshake.
- It emits an on/off flag, a 12-bit Basys3 RGB colour and pixel coordinates. The consumer is the display/frame-buffer writer downstream.

Parameters:
- FG_COLOR, 12'hFFF, RGB (4:4:4) driven for a set glyph bit.
- BG_COLOR, 12'h000, RGB driven for a clear glyph bit.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  asynchronous active-high reset.
- start  input  1  begin one glyph scan; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- rom_addr  output  4  glyph row address to the ROM.
- rom_data  input  16 [0:15]  ROM row word; same-cycle combinational response; bit 0 = leftmost pixel.
- pix_valid  output  1  a pixel is presented.
- pix_ready  input  1  consumer accepts the pixel; a transfer occurs when pix_valid && pix_ready at a clock edge.
- pix_on  output  1  glyph bit of the presented pixel.
- rgb  output  12  FG_COLOR if pix_on, else BG_COLOR.
- pix_x  output  5  column of the presented pixel.
- pix_y  output  5  row of the presented pixel.
- pix_last  output  1  presented pixel is the final pixel of the glyph.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE; row, col and shift register = 0.
- Output reset values: rom_addr=0, busy=0, pix_valid=0, pix_on=0, rgb=BG_COLOR, pix_x=0, pix_y=0, pix_last=0, done=0.
- Reset mid-scan aborts immediately; no done pulse is issued.
- All outputs are driven from registers or state. rom_addr is always the row register, unscaled.
- IDLE: start=1 -> row=0, col=0, go to FETCH. start is ignored in all other states.
- FETCH (exactly one cycle, pix_valid=0): at the clock edge, shift register <= rom_data, col=0, go to SHIFT.
- SHIFT: pix_valid=1.
  - pix_on = current bit; pix_x = col; pix_y = row.
  - While pix_valid && !pix_ready, every output is held stable.
- On a transfer in SHIFT:
  - col < 15: col+1, advance to the next bit.
  - col = 15, row < 15: row+1, go to FETCH (one bubble cycle per row).
  - col = 15, row = 15: go to DONE.
- pix_last = 1 only while presenting (15,15).
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0. start is ignored during DONE.
- Latency:
  - start sampled at edge N -> FETCH during cycle N+1 -> first pix_valid in cycle N+2.
  - With pix_ready held high: 16 x 17 = 272 cycles from the FETCH entry to the last transfer; done follows in the next cycle.
- pix_x[4] and pix_y[4] are always 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: GLYPH_SCALE2X_EN.
- Defined: output is a 32x32 pixel grid, with each glyph bit replicated 2x2.
  - pix_x and pix_y run 0..31.
  - The presented bit is bit pix_x[4:1] of the latched row.
  - rom_addr = pix_y[4:1]; each ROM row is fetched twice, with one FETCH bubble before each of the 32 output rows.
  - pix_last at (31,31).
  - Scan takes 32 x 33 = 1056 cycles with ready held high.
- Undefined: 16x16 behaviour exactly as above.

Test Plan:
- Reset/idle: clr=1 mid-SHIFT at row 7 -> next cycle all outputs at reset values, no done pulse; later start -> rom_addr=0, scan restarts at (0,0).
- Full scan, ready high: ROM row r = 16'h8001 for all r -> pixels (0,y) and (15,y) on with rgb=FG_COLOR, all others BG_COLOR. First valid 2 cycles after start; done 273 cycles after FETCH entry; 256 transfers; pix_last only at (15,15).
- Backpressure: pix_ready toggled by a random 50% pattern with row 3 = 16'hF0F0 -> outputs stable while stalled; row 3 pixels x=0..3 on, x=4..7 off, x=8..11 on, x=12..15 off; transfer count = 256.
- Start ignored: start pulsed while busy and during DONE -> no restart, pixel sequence unaffected, exactly one done pulse.
- Row addressing: ROM returns a unique word per address (e.g. 16'h0001 << addr, leftmost-bit ordering) -> the pix_on pattern matches rom_addr = pix_y.
- Scale (GLYPH_SCALE2X_EN defined): row 0 = 16'hC000 -> pixels x=0..3 on for y=0 and y=1; 1024 transfers; pix_last at (31,31).

Source files
------------

// File: rtl/glyph_raster_reader.sv
// Glyph ROM reader: fetches 16 row words and serializes them as a valid/ready pixel stream.
// Optional 2x2 pixel replication (32x32 output grid) when GLYPH_SCALE2X_EN is defined.
module glyph_raster_reader #(
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  output logic        busy,
  output logic [3:0]  rom_addr,
  input  logic [0:15] rom_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_on,
  output logic [11:0] rgb,
  output logic [4:0]  pix_x,
  output logic [4:0]  pix_y,
  output logic        pix_last,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StFetch, StShift, StDone} state_e;

`ifdef GLYPH_SCALE2X_EN
  localparam logic [4:0] LastIdx = 5'd31;
`else
  localparam logic [4:0] LastIdx = 5'd15;
`endif

  state_e      state_q;
  logic [4:0]  row_q;
  logic [4:0]  col_q;
  logic [0:15] shreg_q;
  logic [3:0]  bit_idx;

`ifdef GLYPH_SCALE2X_EN
  // Each glyph bit and row covers two output columns/rows.
  assign bit_idx  = col_q[4:1];
  assign rom_addr = row_q[4:1];
`else
  assign bit_idx  = col_q[3:0];
  assign rom_addr = row_q[3:0];
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      shreg_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            row_q   <= '0;
            col_q   <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          shreg_q <= rom_data;
          col_q   <= '0;
          state_q <= StShift;
        end
        StShift: begin
          if (pix_ready) begin
            if (col_q != LastIdx) begin
              col_q <= col_q + 5'd1;
            end else if (row_q != LastIdx) begin
              row_q   <= row_q + 5'd1;
              state_q <= StFetch;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign pix_valid = (state_q == StShift);
  assign pix_on    = pix_valid & shreg_q[bit_idx];
  assign rgb       = pix_on ? FG_COLOR : BG_COLOR;
  assign pix_x     = col_q;
  assign pix_y     = row_q;
  assign pix_last  = pix_valid && (col_q == LastIdx) && (row_q == LastIdx);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_glyph_raster_reader.sv
// Scoreboard bench for glyph_raster_reader; follows GLYPH_SCALE2X_EN for the grid size.
module tb_glyph_raster_reader;

`ifdef GLYPH_SCALE2X_EN
  localparam int Grid = 32;
  localparam int Sh   = 1;
`else
  localparam int Grid = 16;
  localparam int Sh   = 0;
`endif
  localparam logic [11:0] Fg = 12'hFFF;
  localparam logic [11:0] Bg = 12'h000;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        busy;
  logic [3:0]  rom_addr;
  logic [0:15] rom_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_on;
  logic [11:0] rgb;
  logic [4:0]  pix_x;
  logic [4:0]  pix_y;
  logic        pix_last;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int pat      = 0;
  logic [11:0] sb[$];  // {last, on, y[4:0], x[4:0]}

  glyph_raster_reader dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .busy     (busy),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_on   (pix_on),
    .rgb      (rgb),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_last (pix_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Numeric word; its MSB is the leftmost pixel (ROM bit 0).
  function automatic logic [15:0] rom_word(input int p, input logic [3:0] a);
    logic [15:0] one;
    one = 16'h0001;
    case (p)
      0:       return 16'h8001;
      1:       return (a == 4'd3) ? 16'hF0F0 : (16'h1234 ^ {12'h000, a});
      2:       return one << a;
      default: return (a == 4'd0) ? 16'hC000 : 16'h0000;
    endcase
  endfunction

  always_comb rom_data = rom_word(pat, rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_on", pix_on, 0);
    check("rst_rgb", rgb, Bg);
    check("rst_x", pix_x, 0);
    check("rst_y", pix_y, 0);
    check("rst_last", pix_last, 0);
    check("rst_done", done, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_scan(input int p, input bit rnd, input bit poke, input int exp_cycles);
    logic [15:0] w;
    logic [11:0] e;
    logic [31:0] snap;
    logic [31:0] prev;
    bit          stalled;
    bit          seen_done;
    int          xfers;
    int          cyc;
    pat = p;
    sb.delete();
    for (int y = 0; y < Grid; y++) begin
      for (int x = 0; x < Grid; x++) begin
        w = rom_word(p, 4'(y >> Sh));
        sb.push_back({(x == Grid - 1) && (y == Grid - 1), w[15 - (x >> Sh)], 5'(y), 5'(x)});
      end
    end
    stalled   = 1'b0;
    seen_done = 1'b0;
    xfers     = 0;
    cyc       = 0;
    prev      = '0;
    pix_ready = 1'b1;
    pulse_start();
    check("fetch_valid", pix_valid, 0);
    check("fetch_busy", busy, 1);
    check("fetch_addr", rom_addr, 0);
    while (!seen_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) start = ($urandom_range(0, 3) == 0);
      if (cyc == 1) check("first_valid", pix_valid, 1);
      snap = {3'b0, pix_valid, pix_on, rgb, pix_x, pix_y, pix_last, rom_addr};
      if (stalled) check("stall_hold", snap, prev);
      stalled = pix_valid && !pix_ready;
      prev    = snap;
      if (pix_valid && pix_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pix_x", pix_x, e[4:0]);
          check("pix_y", pix_y, e[9:5]);
          check("pix_on", pix_on, e[10]);
          check("rgb", rgb, e[10] ? Fg : Bg);
          check("pix_last", pix_last, e[11]);
          check("rom_addr", rom_addr, e[9:5] >> Sh);
        end
        xfers++;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_busy", busy, 1);
        check("done_valid", pix_valid, 0);
        if (exp_cycles > 0) check("done_latency", cyc, exp_cycles);
        if (poke) start = 1'b1;
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    @(negedge clk) start = 1'b0;
    check("idle_busy", busy, 0);
    check("done_single", done, 0);
    check("xfer_count", xfers, Grid * Grid);
    check("sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
    check("idle_stays", busy, 0);
  endtask

  task automatic abort_mid_scan();
    int cyc;
    bit hit;
    pat       = 1;
    pix_ready = 1'b1;
    hit       = 1'b0;
    cyc       = 0;
    pulse_start();
    while (!hit && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (pix_valid && pix_y == 5'(7 << Sh)) hit = 1'b1;
    end
    check("abort_reached_row7", hit, 1);
    #1 clr = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    check("abort_no_done", done, 0);
    check("abort_idle", busy, 0);
    clr = 1'b0;
    @(negedge clk);
    check("abort_after_done", done, 0);
  endtask

  initial begin
    clr       = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    clr = 1'b0;
    @(negedge clk);
    check("idle_after_rst", busy, 0);

    run_scan(0, 1'b0, 1'b0, Grid * (Grid + 1));
    run_scan(1, 1'b1, 1'b0, 0);
    run_scan(2, 1'b0, 1'b1, Grid * (Grid + 1));
    abort_mid_scan();
    run_scan(2, 1'b1, 1'b0, 0);
    run_scan(3, 1'b0, 1'b0, Grid * (Grid + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
